// File: rtl/ram_sync_if.sv
// Access bus of the synchronous single-port RAM: address/control/write data
// from the controller, registered read data and status back from the RAM.
interface ram_sync_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] adr;
  logic              we;
  logic [DATA_W-1:0] din;
  logic              re;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              busy;
  logic              err;

  modport master (
    output adr, we, din, re,
    input  dout, dout_valid, busy, err
  );

  modport slave (
    input  adr, we, din, re,
    output dout, dout_valid, busy, err
  );
endinterface

// File: rtl/ram_sync.sv
// Synchronous single-port RAM with registered read, valid strobe, selectable
// read-during-write policy, optional post-reset clear sweep and out-of-range
// address detection.
module ram_sync #(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DEPTH      = 65536,
  parameter int unsigned READ_MODE  = 0,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic       clk,
  input  logic       rst,
  ram_sync_if.slave  bus
);

  localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_ADR = CNT_W'(DEPTH - 1);
  // One extra bit so DEPTH == 2**ADDR_W is representable in the range check.
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  localparam state_t RST_STATE = (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;
  logic              r_err;

  logic              w_in_range;
  logic              w_idle;
  logic [CNT_W-1:0]  w_adr_idx;
  logic              w_mem_we;
  logic [CNT_W-1:0]  w_mem_adr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [DATA_W-1:0] w_rd_data;

  // Full-width compare: no wrap-around of addresses beyond DEPTH.
  assign w_in_range = ({1'b0, bus.adr} < DEPTH_X);
  assign w_adr_idx  = bus.adr[CNT_W-1:0];
  assign w_idle     = (r_state == ST_IDLE);

  // State register; reset restarts the clear sweep when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RST_STATE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: leave CLEAR on the edge that writes the last word.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_CLEAR: if (r_cnt == LAST_ADR) w_state_next = ST_IDLE;
      default:  w_state_next = r_state;
    endcase
  end

  // Clear sweep address counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Write port arbitration: clear sweep owns the port while busy.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_adr   = '0;
    w_mem_wdata = '0;
    if (!rst) begin
      if (r_state == ST_CLEAR) begin
        w_mem_we  = 1'b1;
        w_mem_adr = r_cnt;
      end else if (bus.we && w_in_range) begin
        w_mem_we    = 1'b1;
        w_mem_adr   = w_adr_idx;
        w_mem_wdata = bus.din;
      end
    end
  end

  // Storage array; deliberately not touched by rst.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_adr] <= w_mem_wdata;
    end
  end

  // Read-during-write data selection for a same-edge access.
  always_comb begin
    w_rd_data = r_mem[w_adr_idx];
    if ((READ_MODE != 0) && bus.we) begin
      w_rd_data = bus.din;
    end
  end

  // Registered read data, valid strobe and out-of-range error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_err        <= 1'b0;
    end else if (!w_idle) begin
      r_dout_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_dout_valid <= bus.re;
      r_err        <= (bus.re || bus.we) && !w_in_range;
      if (bus.re) begin
        r_dout <= w_in_range ? w_rd_data : '0;
      end
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.err        = r_err;
  assign bus.busy       = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_ram_sync.sv
// Directed bench for ram_sync: three configurations (full-size read-first,
// small write-first with clear, small without clear).
module tb_ram_sync;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  logic rst2 = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  ram_sync_if #(.DATA_W(4), .ADDR_W(16)) if0 ();
  ram_sync_if #(.DATA_W(4), .ADDR_W(8))  if1 ();
  ram_sync_if #(.DATA_W(4), .ADDR_W(8))  if2 ();

  ram_sync #(.DATA_W(4), .ADDR_W(16), .DEPTH(65536), .READ_MODE(0), .INIT_CLEAR(1))
    u0 (.clk(clk), .rst(rst0), .bus(if0.slave));
  ram_sync #(.DATA_W(4), .ADDR_W(8), .DEPTH(16), .READ_MODE(1), .INIT_CLEAR(1))
    u1 (.clk(clk), .rst(rst1), .bus(if1.slave));
  ram_sync #(.DATA_W(4), .ADDR_W(8), .DEPTH(16), .READ_MODE(0), .INIT_CLEAR(0))
    u2 (.clk(clk), .rst(rst2), .bus(if2.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int  n;
  bit  bad;

  initial begin
    if0.adr = '0; if0.we = 0; if0.din = '0; if0.re = 0;
    if1.adr = '0; if1.we = 0; if1.din = '0; if1.re = 0;
    if2.adr = '0; if2.we = 0; if2.din = '0; if2.re = 0;
    #2;
    tick();
    // Reset state
    check("u2_rst_dout",  32'(if2.dout), 0);
    check("u2_rst_valid", 32'(if2.dout_valid), 0);
    check("u2_rst_busy",  32'(if2.busy), 0);
    check("u2_rst_err",   32'(if2.err), 0);
    check("u1_rst_busy",  32'(if1.busy), 1);

    // INIT_CLEAR=0: contents survive reset
    rst2 = 0;
    if2.we = 1; if2.adr = 8'd1; if2.din = 4'hC; tick();
    if2.we = 0; if2.re = 1; tick();
    check("u2_rd1", 32'(if2.dout), 32'hC);
    if2.re = 0; rst2 = 1; tick();
    check("u2_rst2_dout",  32'(if2.dout), 0);
    check("u2_rst2_valid", 32'(if2.dout_valid), 0);
    check("u2_rst2_busy",  32'(if2.busy), 0);
    rst2 = 0; if2.re = 1; tick();
    check("u2_keep",       32'(if2.dout), 32'hC);
    check("u2_keep_valid", 32'(if2.dout_valid), 1);
    if2.re = 0;

    // DEPTH=16 clear length
    rst1 = 0; n = 0;
    while (n < 40) begin tick(); n++; if (!if1.busy) break; end
    check("u1_clear_len", 32'(n), 16);

    // Write-first read during write
    if1.we = 1; if1.adr = 8'd3; if1.din = 4'hF; tick();
    if1.adr = 8'd5; if1.din = 4'h7; tick();
    if1.re = 1; if1.din = 4'h9; tick();
    check("u1_rdw_dout", 32'(if1.dout), 32'h9);
    if1.we = 0; tick();
    check("u1_rdw_after", 32'(if1.dout), 32'h9);

    // Out of range
    if1.re = 0; if1.we = 1; if1.adr = 8'd20; if1.din = 4'hA; tick();
    check("u1_oor_wr_err",   32'(if1.err), 1);
    check("u1_oor_wr_valid", 32'(if1.dout_valid), 0);
    if1.we = 0; tick();
    check("u1_err_pulse", 32'(if1.err), 0);
    if1.re = 1; if1.adr = 8'd3; tick();
    check("u1_rd3", 32'(if1.dout), 32'hF);
    if1.adr = 8'd20; tick();
    check("u1_oor_rd_dout",  32'(if1.dout), 0);
    check("u1_oor_rd_err",   32'(if1.err), 1);
    check("u1_oor_rd_valid", 32'(if1.dout_valid), 1);
    if1.adr = 8'd4; tick();
    check("u1_rd4_dout", 32'(if1.dout), 0);
    check("u1_rd4_err",  32'(if1.err), 0);
    if1.re = 0;

    // Reset in mid-clear with write attempts while busy
    rst1 = 1; tick();
    rst1 = 0;
    for (int i = 0; i < 8; i++) begin
      if1.we = (i % 2 == 0); if1.adr = 8'd3; if1.din = 4'hF; tick();
    end
    check("u1_busy_mid", 32'(if1.busy), 1);
    if1.we = 0; rst1 = 1; tick();
    rst1 = 0; if1.we = 1; if1.re = 1; n = 0; bad = 0;
    while (n < 40) begin
      tick(); n++;
      if (if1.dout_valid || if1.err) bad = 1;
      if (!if1.busy) break;
    end
    check("u1_reclear_len", 32'(n), 16);
    check("u1_busy_quiet",  32'(bad), 0);
    if1.we = 0; tick();
    check("u1_rd3_cleared", 32'(if1.dout), 0);
    check("u1_rd3_valid",   32'(if1.dout_valid), 1);
    if1.re = 0;

    // Full-size clear, read held during sweep
    tick();
    rst0 = 0; if0.re = 1; if0.adr = '0; n = 0; bad = 0;
    while (n < 70000) begin
      tick(); n++;
      if (if0.dout_valid) bad = 1;
      if (!if0.busy) break;
    end
    check("u0_clear_len",   32'(n), 65536);
    check("u0_busy_quiet",  32'(bad), 0);
    tick();
    check("u0_first_dout",  32'(if0.dout), 0);
    check("u0_first_valid", 32'(if0.dout_valid), 1);

    // Writes then back-to-back reads
    if0.re = 0; if0.we = 1;
    if0.adr = 16'd0; if0.din = 4'd3;  tick();
    if0.adr = 16'd1; if0.din = 4'd10; tick();
    if0.adr = 16'd2; if0.din = 4'd15; tick();
    if0.we = 0; if0.re = 1;
    if0.adr = 16'd0; tick();
    check("u0_rd0", 32'(if0.dout), 3);
    check("u0_rd0_valid", 32'(if0.dout_valid), 1);
    if0.adr = 16'd1; tick();
    check("u0_rd1", 32'(if0.dout), 10);
    check("u0_rd1_valid", 32'(if0.dout_valid), 1);
    if0.adr = 16'd2; tick();
    check("u0_rd2", 32'(if0.dout), 15);
    check("u0_rd2_valid", 32'(if0.dout_valid), 1);
    if0.re = 0; tick();
    check("u0_hold", 32'(if0.dout), 15);
    check("u0_hold_valid", 32'(if0.dout_valid), 0);

    // Read-first read during write
    if0.we = 1; if0.adr = 16'd5; if0.din = 4'd7; tick();
    if0.re = 1; if0.din = 4'd9; tick();
    check("u0_rdw_dout", 32'(if0.dout), 7);
    if0.we = 0; tick();
    check("u0_rdw_after", 32'(if0.dout), 9);

    // Top address is in range when DEPTH == 2**ADDR_W
    if0.adr = 16'hFFFF; tick();
    check("u0_top_dout", 32'(if0.dout), 0);
    check("u0_top_err",  32'(if0.err), 0);
    if0.re = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
